// File: rtl/dp_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dp_sched_pkg
// Purpose  : Shared definitions for the dp_sched_ctrl scheduler slice.
//            - default operand width and multiplier latency
//            - FSM state encoding
//            - saturating clamp of an exact add result (used only when
//              DP_SCHED_SAT_EN is defined)
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dp_sched_pkg;

  localparam int DEF_W       = 8;
  localparam int DEF_MUL_LAT = 2;

  // Scheduler state encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADD_D = 3'd1;
  localparam logic [2:0] S_ADD_E = 3'd2;
  localparam logic [2:0] S_CMP   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_SUB   = 3'd5;

  // Clamp an exact (non-wrapped) two-operand sum into the signed range of
  // a w-bit result. The caller truncates the return value to w bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] sum,
                                                 input int unsigned        w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dp_mul_pipe
// Purpose  : MUL_LAT-stage signed W x W -> 2W multiplier with a valid
//            shift register. The valid chain is cleared by reset; the data
//            stages are not, since data is only consumed under valid.
// Ports    : Clk         - clock
//            Rst         - synchronous active-low clear of the valid chain
//            in_vld      - issue strobe for the operands on a/b
//            a, b        - signed W-bit operands
//            p           - signed 2W-bit product (exact)
//            p_vld       - product on p is valid (one-cycle pulse)
//            p_vld_early - p_vld will be high in the next cycle
// Revision : 1.0 - initial release
// ============================================================================
module dp_mul_pipe
  import dp_sched_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           in_vld,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p,
  output logic           p_vld,
  output logic           p_vld_early
);

  logic [MUL_LAT-1:0] r_vld;
  logic [2*W-1:0]     r_p [MUL_LAT];
  logic [2*W-1:0]     w_prod;

  // Sign-extend to 2W first so the low 2W bits of the unsigned product are
  // the exact signed product.
  assign w_prod = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};

  always_ff @(posedge Clk) begin
    r_p[0] <= w_prod;
    for (int i = 1; i < MUL_LAT; i++) begin
      r_p[i] <= r_p[i-1];
    end
  end

  generate
    if (MUL_LAT == 1) begin : g_lat1
      always_ff @(posedge Clk) begin
        if (!Rst) begin
          r_vld <= '0;
        end else begin
          r_vld <= in_vld;
        end
      end
      assign p_vld_early = in_vld;
    end else begin : g_latn
      always_ff @(posedge Clk) begin
        if (!Rst) begin
          r_vld <= '0;
        end else begin
          r_vld <= {r_vld[MUL_LAT-2:0], in_vld};
        end
      end
      assign p_vld_early = r_vld[MUL_LAT-2];
    end
  endgenerate

  assign p     = r_p[MUL_LAT-1];
  assign p_vld = r_vld[MUL_LAT-1];

endmodule
`default_nettype wire

// File: rtl/dp_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dp_sched_ctrl
// Purpose  : Multi-cycle scheduler computing d=a+b, e=a+c, z=max(d,e),
//            x=a*c-d with one shared add/sub/compare ALU and a pipelined
//            multiplier. start/busy/done handshake.
//            Build option DP_SCHED_SAT_EN: d and e saturate instead of wrap.
// Ports    : Clk      - clock
//            Rst      - synchronous active-low reset
//            start    - request, sampled only while idle
//            a, b, c  - signed W-bit operands, latched on accepted start
//            busy     - operation in flight
//            done     - one-cycle pulse, z/x/ovf updated in this cycle
//            z        - signed max(d,e)
//            x        - signed a*c - d at 2W bits
//            ovf      - d or e overflowed W bits
// Revision : 1.0 - initial release
// ============================================================================
module dp_sched_ctrl
  import dp_sched_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [W-1:0]   c,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   z,
  output logic [2*W-1:0] x,
  output logic           ovf
);

  logic [2:0]     r_state;
  logic [W-1:0]   r_a, r_b, r_c, r_d, r_e, r_zr, r_z;
  logic [2*W-1:0] r_x;
  logic           r_ovf_acc, r_ovf, r_done, r_p_rdy;

  logic [2*W-1:0] w_p, w_alu_a, w_alu_b, w_alu_r;
  logic           w_alu_sub, w_p_vld, w_p_vld_early, w_prod_rdy;
  logic           w_mul_issue, w_add_ovf;
  logic [W-1:0]   w_add_val;

  function automatic logic [2*W-1:0] sext(input logic [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction

  assign w_mul_issue = (r_state == S_ADD_D);

  dp_mul_pipe #(
    .W       (W),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .Clk         (Clk),
    .Rst         (Rst),
    .in_vld      (w_mul_issue),
    .a           (r_a),
    .b           (r_c),
    .p           (w_p),
    .p_vld       (w_p_vld),
    .p_vld_early (w_p_vld_early)
  );

  // Product is usable in the next cycle if it arrives next cycle, arrives
  // now, or already arrived (short multiplier latencies finish before CMP).
  assign w_prod_rdy = w_p_vld_early | w_p_vld | r_p_rdy;

  // Shared ALU: operand routing by state, 2W-bit add/sub
  always_comb begin
    w_alu_a   = '0;
    w_alu_b   = '0;
    w_alu_sub = 1'b0;
    case (r_state)
      S_ADD_D: begin
        w_alu_a = sext(r_a);
        w_alu_b = sext(r_b);
      end
      S_ADD_E: begin
        w_alu_a = sext(r_a);
        w_alu_b = sext(r_c);
      end
      S_CMP: begin
        // e - d < 0  <=>  d > e ; exact at 2W bits
        w_alu_a   = sext(r_e);
        w_alu_b   = sext(r_d);
        w_alu_sub = 1'b1;
      end
      S_SUB: begin
        w_alu_a   = w_p;
        w_alu_b   = sext(r_d);
        w_alu_sub = 1'b1;
      end
      default: begin
        w_alu_sub = 1'b0;
      end
    endcase
  end

  assign w_alu_r = w_alu_sub ? (w_alu_a - w_alu_b) : (w_alu_a + w_alu_b);

  // The 2W-bit sum is exact; it overflowed W bits if it differs from the
  // sign extension of its own low W bits.
  assign w_add_ovf = (w_alu_r != sext(w_alu_r[W-1:0]));

`ifdef DP_SCHED_SAT_EN
  assign w_add_val = W'(sat_add(64'($signed(w_alu_r)), W));
`else
  assign w_add_val = w_alu_r[W-1:0];
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= '0;
      r_d       <= '0;
      r_e       <= '0;
      r_zr      <= '0;
      r_z       <= '0;
      r_x       <= '0;
      r_ovf_acc <= 1'b0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
      r_p_rdy   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (r_state == S_IDLE) begin
        r_p_rdy <= 1'b0;
      end else if (w_p_vld) begin
        r_p_rdy <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= c;
            r_state <= S_ADD_D;
          end
        end
        S_ADD_D: begin
          r_d       <= w_add_val;
          r_ovf_acc <= w_add_ovf;
          r_state   <= S_ADD_E;
        end
        S_ADD_E: begin
          r_e       <= w_add_val;
          r_ovf_acc <= r_ovf_acc | w_add_ovf;
          r_state   <= S_CMP;
        end
        S_CMP: begin
          r_zr    <= w_alu_r[2*W-1] ? r_d : r_e;
          r_state <= w_prod_rdy ? S_SUB : S_WAIT;
        end
        S_WAIT: begin
          if (w_prod_rdy) begin
            r_state <= S_SUB;
          end
        end
        S_SUB: begin
          r_z     <= r_zr;
          r_x     <= w_alu_r;
          r_ovf   <= r_ovf_acc;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign z    = r_z;
  assign x    = r_x;
  assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dp_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_sched_ctrl
// Purpose  : Self-checking bench for dp_sched_ctrl. Two instances: default
//            MUL_LAT=2 and MUL_LAT=5. Expected results come from an
//            arithmetic reference model; DP_SCHED_SAT_EN selects the
//            saturating model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start5 = 1'b0;
  logic [7:0]  a = '0, b = '0, c = '0, a5 = '0, b5 = '0, c5 = '0;
  logic        busy, done, ovf, busy5, done5, ovf5;
  logic [7:0]  z, z5;
  logic [15:0] x, x5;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dp_sched_ctrl dut (
    .Clk   (clk),
    .Rst   (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .x     (x),
    .ovf   (ovf)
  );

  dp_sched_ctrl #(.MUL_LAT(5)) dut5 (
    .Clk   (clk),
    .Rst   (rst_n),
    .start (start5),
    .a     (a5),
    .b     (b5),
    .c     (c5),
    .busy  (busy5),
    .done  (done5),
    .z     (z5),
    .x     (x5),
    .ovf   (ovf5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the signed operands
  function automatic void model(input logic [7:0] ia, ib, ic,
                                output logic [7:0] ez, output logic [15:0] ex,
                                output logic eo);
    int sa, sb, sc, dfull, efull, dv, ev, zv, xv;
    sa = $signed(ia);
    sb = $signed(ib);
    sc = $signed(ic);
    dfull = sa + sb;
    efull = sa + sc;
    eo = (dfull > 127) || (dfull < -128) || (efull > 127) || (efull < -128);
`ifdef DP_SCHED_SAT_EN
    dv = (dfull > 127) ? 127 : ((dfull < -128) ? -128 : dfull);
    ev = (efull > 127) ? 127 : ((efull < -128) ? -128 : efull);
`else
    dv = ((dfull + 128) & 255) - 128;
    ev = ((efull + 128) & 255) - 128;
`endif
    zv = (dv > ev) ? dv : ev;
    xv = sa * sc - dv;
    ez = zv[7:0];
    ex = xv[15:0];
  endfunction

  task automatic launch(input bit sel, input logic [7:0] ia, ib, ic);
    if (sel) begin
      a5 = ia; b5 = ib; c5 = ic; start5 = 1'b1;
    end else begin
      a = ia; b = ib; c = ic; start = 1'b1;
    end
    tick();
    start  = 1'b0;
    start5 = 1'b0;
  endtask

  // Called in cycle cyc0 after the accepting edge; returns in the done cycle
  task automatic wait_done(input bit sel, input string tag,
                           input logic [7:0] ia, ib, ic,
                           input int exp_lat, input int cyc0);
    logic [7:0]  ez;
    logic [15:0] ex;
    logic        eo;
    int          cyc;
    model(ia, ib, ic, ez, ex, eo);
    cyc = cyc0;
    while (((sel ? done5 : done) !== 1'b1) && cyc < 40) begin
      chk({tag, "/busy"}, 64'(sel ? busy5 : busy), 64'd1);
      tick();
      cyc++;
    end
    chk({tag, "/latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "/busy_at_done"}, 64'(sel ? busy5 : busy), 64'd0);
    chk({tag, "/z"},   64'(sel ? z5 : z),     64'(ez));
    chk({tag, "/x"},   64'(sel ? x5 : x),     64'(ex));
    chk({tag, "/ovf"}, 64'(sel ? ovf5 : ovf), 64'(eo));
  endtask

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } vec_t;

  initial begin
    vec_t vecs [7];
    logic [7:0] ra, rb, rc;
    int k;

    vecs[0] = '{8'd3,    8'd4,    8'd5};
    vecs[1] = '{8'hFE,   8'd10,   8'hFD};
    vecs[2] = '{8'd100,  8'd100,  8'd1};
    vecs[3] = '{8'h80,   8'h80,   8'h80};
    vecs[4] = '{8'd127,  8'd0,    8'd1};
    vecs[5] = '{8'd127,  8'd1,    8'd0};
    vecs[6] = '{8'h80,   8'hFF,   8'd0};

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst/busy", 64'(busy), 64'd0);
    chk("rst/done", 64'(done), 64'd0);
    chk("rst/z",    64'(z),    64'd0);
    chk("rst/x",    64'(x),    64'd0);
    chk("rst/ovf",  64'(ovf),  64'd0);
    chk("rst/busy5", 64'(busy5), 64'd0);
    chk("rst/done5", 64'(done5), 64'd0);
    rst_n = 1'b1;

    // Directed vectors, including add-overflow boundaries
    for (int i = 0; i < 7; i++) begin
      launch(1'b0, vecs[i].a, vecs[i].b, vecs[i].c);
      wait_done(1'b0, $sformatf("dir%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, 5, 1);
    end
    // done is a single pulse and results hold afterwards
    tick();
    chk("hold/done", 64'(done), 64'd0);
    chk("hold/z", 64'(z), 64'h7F);

    // start pulsed while busy (cycles 2 and 3) with different operands
    launch(1'b0, 8'd6, 8'hFF, 8'd7);
    tick();
    start = 1'b1; a = 8'd50; b = 8'd50; c = 8'd50;
    tick();
    tick();
    start = 1'b0;
    wait_done(1'b0, "ignore", 8'd6, 8'hFF, 8'd7, 5, 4);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) k++;
    end
    chk("ignore/extra_done", 64'(k), 64'd0);

    // Back-to-back: new start held in the done cycle
    launch(1'b0, 8'd3, 8'd4, 8'd5);
    wait_done(1'b0, "b2b_first", 8'd3, 8'd4, 8'd5, 5, 1);
    launch(1'b0, 8'hF9, 8'd2, 8'd9);
    wait_done(1'b0, "b2b_second", 8'hF9, 8'd2, 8'd9, 5, 1);

    // Reset asserted during CMP abandons the operation
    launch(1'b0, 8'd20, 8'd30, 8'hFC);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst/busy", 64'(busy), 64'd0);
    chk("midrst/done", 64'(done), 64'd0);
    chk("midrst/z",    64'(z),    64'd0);
    chk("midrst/x",    64'(x),    64'd0);
    chk("midrst/ovf",  64'(ovf),  64'd0);
    k = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) k++;
    end
    chk("midrst/no_done", 64'(k), 64'd0);

    // Randomized operations against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 8'($urandom);
      launch(1'b0, ra, rb, rc);
      wait_done(1'b0, $sformatf("rnd%0d", i), ra, rb, rc, 5, 1);
    end

    // Long multiplier latency: two WAIT cycles, done at cycle 7
    launch(1'b1, 8'd3, 8'd4, 8'd5);
    wait_done(1'b1, "lat5", 8'd3, 8'd4, 8'd5, 7, 1);
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 8'($urandom);
      launch(1'b1, ra, rb, rc);
      wait_done(1'b1, $sformatf("lat5_rnd%0d", i), ra, rb, rc, 7, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
